mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, DPI-backed data RAM of the miniRV core between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Each requester uses a valid/ready request handshake and receives a single-cycle response pulse.
- The block serialises accesses through a small FSM, adds a programmable access latency to emulate slow memory, and drives the RAM's wen/wdata/wstrb/addr; read data comes back from the RAM's combinational read port.

Parameters:
LATENCY, 1, cycles spent in ACCESS per transaction; legal range 1..15; counter is 4 bits.
LSU_PRIORITY, 0, 0 = round-robin between IFU and LSU; 1 = LSU always wins ties.

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  32  IFU byte address
ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid
ifu_rdata  out  32  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  32  LSU byte address
lsu_wdata  in  32  store data
lsu_wstrb  in  4  store byte enables
lsu_resp_valid  out  1  one-cycle pulse: load data / store completion
lsu_rdata  out  32  LSU read data
ram_wen  out  1  RAM write enable
ram_wdata  out  32  RAM write data
ram_wstrb  out  4  RAM byte strobes
ram_addr  out  32  RAM address
ram_read_data  in  32  RAM combinational read data

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, count = 0, last_grant = LSU, rdata_q = 0, both resp_valid = 0.
  - All ram_* outputs are 0.
- FSM states: IDLE and ACCESS.
- IDLE, grant selection (combinational):
  - Only one valid requester: that requester is granted.
  - Both valid and LSU_PRIORITY=1: LSU is granted.
  - Both valid and LSU_PRIORITY=0: the requester not equal to last_grant is granted.
  - The granted requester's req_ready = 1; the other's = 0.
  - In ACCESS, both req_ready = 0.
- Acceptance (valid && ready at a posedge):
  - Latch owner, addr, wen (always 0 for IFU), wdata, wstrb.
  - Set last_grant = owner, count = LATENCY-1, state = ACCESS.
  - The requester may change its inputs afterwards without effect.
  - Dropping valid before acceptance is legal and withdraws the request.
- ACCESS:
  - ram_addr = latched addr; ram_wdata and ram_wstrb come from the latches.
  - ram_wen = latched wen only while count==0; it is 0 otherwise. Each store therefore commits exactly once.
  - If count != 0, decrement count.
  - If count == 0 at the posedge:
    - rdata_q <= ram_read_data. This is the pre-write value for stores.
    - The owner's resp_valid <= 1 for exactly one cycle.
    - state <= IDLE.
- ram_* outputs are 0 in IDLE.
- ifu_rdata = lsu_rdata = rdata_q. rdata_q holds until the next completion; it is only meaningful while the port's own resp_valid is high.
- Timing:
  - Response latency is LATENCY+1 cycles from the acceptance cycle.
  - A new request may be accepted in the same cycle a resp_valid pulse is high.
  - Peak throughput is 1 request per LATENCY+1 cycles.
- There is no response backpressure; requesters must consume the pulse.
- Stores with wstrb = 0: ram_wen is still pulsed with zero strobes, memory is unchanged, and a response is issued.
- Round-robin fairness: with both requesters held valid continuously, grants strictly alternate, starting with IFU after reset.
- Reset mid-ACCESS: the transaction is aborted, no ram_wen pulse occurs, and no response is issued.
- Address alignment is not checked; the address is passed through unmodified.

Test Plan:
- LATENCY=1, IFU reads 0x80000000 (RAM holds 0x00100093) → ifu_req_ready high in acceptance cycle t; ifu_resp_valid pulse at t+2 with ifu_rdata=0x00100093; ram_wen never asserted.
- LSU store addr 0x80000010, wdata 0xDEADBEEF, wstrb 4'b0011 → exactly one ram_wen cycle with those values; lsu_resp_valid pulses; a subsequent LSU load returns lower half 0xBEEF merged with the old upper half.
- Both valid continuously for 6 grants, LSU_PRIORITY=0 → grant order IFU, LSU, IFU, LSU, IFU, LSU; each resp_valid goes only to its owner; a new acceptance occurs in each response cycle.
- Same contention with LSU_PRIORITY=1 → LSU granted every time; IFU ready stays 0 until LSU drops valid.
- LATENCY=4, LSU load → ram_addr stable for 4 ACCESS cycles; resp at acceptance+5; both req_ready low throughout ACCESS.
- Assert reset during the ACCESS phase of a store (LATENCY=3) → no ram_wen pulse and no resp_valid; after release, state is IDLE and the first tie is granted to IFU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: IFU (read-only) and LSU (read/write)
// are serialised through an IDLE/ACCESS FSM with a programmable access latency.
//
// state  | meaning
// IDLE   | no access in flight; grant logic may accept one request
// ACCESS | latched request driven onto the RAM for LATENCY cycles
module mem_arbiter #(
  parameter int unsigned LATENCY      = 1,
  parameter bit          LSU_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,

  output logic        ram_wen,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  owner_t      owner_q;
  owner_t      last_grant;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wen_q;
  logic [31:0] rdata_q;
  logic        ifu_resp_q;
  logic        lsu_resp_q;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        in_access;

  // Ties go to the requester that did not win last time, unless the LSU is favoured.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (LSU_PRIORITY || (last_grant == OWN_IFU)) begin
          grant_lsu = 1'b1;
        end else begin
          grant_ifu = 1'b1;
        end
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_q    <= OWN_IFU;
      last_grant <= OWN_LSU;
      count      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      wen_q      <= 1'b0;
      rdata_q    <= 32'd0;
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      if (state == IDLE) begin
        if (grant_ifu || grant_lsu) begin
          owner_q    <= grant_lsu ? OWN_LSU : OWN_IFU;
          last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
          addr_q     <= grant_lsu ? lsu_addr : ifu_addr;
          wen_q      <= grant_lsu & lsu_wen;
          wdata_q    <= grant_lsu ? lsu_wdata : 32'd0;
          wstrb_q    <= grant_lsu ? lsu_wstrb : 4'd0;
          count      <= COUNT_INIT;
          state      <= ACCESS;
        end
      end else begin
        if (count != 4'd0) begin
          count <= count - 4'd1;
        end else begin
          // For stores this captures the pre-write word from the combinational read port.
          rdata_q <= ram_read_data;
          if (owner_q == OWN_LSU) begin
            lsu_resp_q <= 1'b1;
          end else begin
            ifu_resp_q <= 1'b1;
          end
          state <= IDLE;
        end
      end
    end
  end

  assign in_access = (state == ACCESS);

  // The write strobe is confined to the final ACCESS cycle so each store commits once.
  assign ram_wen   = in_access && wen_q && (count == 4'd0);
  assign ram_addr  = in_access ? addr_q  : 32'd0;
  assign ram_wdata = in_access ? wdata_q : 32'd0;
  assign ram_wstrb = in_access ? wstrb_q : 4'd0;

  assign ifu_resp_valid = ifu_resp_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign ifu_rdata      = rdata_q;
  assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: four instances with different LATENCY/LSU_PRIORITY
// settings, each with its own behavioural RAM; responses are checked against a scoreboard.
module tb_mem_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ifu_req_valid [N];
  logic        ifu_req_ready [N];
  logic [31:0] ifu_addr      [N];
  logic        ifu_resp_valid[N];
  logic [31:0] ifu_rdata     [N];
  logic        lsu_req_valid [N];
  logic        lsu_req_ready [N];
  logic        lsu_wen       [N];
  logic [31:0] lsu_addr      [N];
  logic [31:0] lsu_wdata     [N];
  logic [3:0]  lsu_wstrb     [N];
  logic        lsu_resp_valid[N];
  logic [31:0] lsu_rdata     [N];
  logic        ram_wen       [N];
  logic [31:0] ram_wdata     [N];
  logic [3:0]  ram_wstrb     [N];
  logic [31:0] ram_addr      [N];
  logic [31:0] ram_read_data [N];

  typedef struct {
    int          inst;
    bit          lsu;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0010_0093;
    return {8'hC0, 8'(i), 16'h1234 + 16'(i)};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? 4 : ((k == 3) ? 3 : 1);
  endfunction

  function automatic int pending(input int k);
    int n = 0;
    foreach (sb[j]) if (sb[j].inst == k) n++;
    return n;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem [64];

    mem_arbiter #(
      .LATENCY     (g == 2 ? 4 : (g == 3 ? 3 : 1)),
      .LSU_PRIORITY(g == 1 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .ifu_req_valid (ifu_req_valid[g]),
      .ifu_req_ready (ifu_req_ready[g]),
      .ifu_addr      (ifu_addr[g]),
      .ifu_resp_valid(ifu_resp_valid[g]),
      .ifu_rdata     (ifu_rdata[g]),
      .lsu_req_valid (lsu_req_valid[g]),
      .lsu_req_ready (lsu_req_ready[g]),
      .lsu_wen       (lsu_wen[g]),
      .lsu_addr      (lsu_addr[g]),
      .lsu_wdata     (lsu_wdata[g]),
      .lsu_wstrb     (lsu_wstrb[g]),
      .lsu_resp_valid(lsu_resp_valid[g]),
      .lsu_rdata     (lsu_rdata[g]),
      .ram_wen       (ram_wen[g]),
      .ram_wdata     (ram_wdata[g]),
      .ram_wstrb     (ram_wstrb[g]),
      .ram_addr      (ram_addr[g]),
      .ram_read_data (ram_read_data[g])
    );

    assign ram_read_data[g] = mem[ram_addr[g][7:2]];

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (ram_wen[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[g][b]) mem[ram_addr[g][7:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
    end
  end

  // Scoreboard: every response pulse must match the oldest expectation for that instance.
  always @(negedge clk) begin
    int          idx;
    exp_t        e;
    logic [31:0] got;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (ifu_resp_valid[k] || lsu_resp_valid[k]) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].inst == k) idx = j;
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL resp_unexpected inst=%0d cyc=%0d ifu=%b lsu=%b, required no response",
                     k, cyc, ifu_resp_valid[k], lsu_resp_valid[k]);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            got = e.lsu ? lsu_rdata[k] : ifu_rdata[k];
            if ({ifu_resp_valid[k], lsu_resp_valid[k]} !== (e.lsu ? 2'b01 : 2'b10) ||
                cyc !== e.due || got !== e.data) begin
              bad++;
              $display("FAIL resp inst=%0d got ifu/lsu=%b%b cyc=%0d data=%h, required lsu=%0d cyc=%0d data=%h",
                       k, ifu_resp_valid[k], lsu_resp_valid[k], cyc, got, e.lsu, e.due, e.data);
            end
          end
        end
      end
    end
  end

  task automatic issue_ifu(input int k, input logic [31:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    ifu_req_valid[k] = 1'b1;
    ifu_addr[k]      = a;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (ifu_req_ready[k]) begin
        ok = 1'b1;
        sb.push_back('{inst: k, lsu: 1'b0, data: d, due: cyc + lat_of(k) + 1});
      end
      @(posedge clk); #1;
    end
    ifu_req_valid[k] = 1'b0;
    ifu_addr[k]      = 32'hFFFF_FFFC;
  endtask

  task automatic issue_lsu(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] d, input bit push, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    lsu_req_valid[k] = 1'b1;
    lsu_wen[k]       = w;
    lsu_addr[k]      = a;
    lsu_wdata[k]     = wd;
    lsu_wstrb[k]     = ws;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (lsu_req_ready[k]) begin
        ok = 1'b1;
        if (push) sb.push_back('{inst: k, lsu: 1'b1, data: d, due: cyc + lat_of(k) + 1});
      end
      @(posedge clk); #1;
    end
    lsu_req_valid[k] = 1'b0;
    lsu_wen[k]       = 1'b1;
    lsu_addr[k]      = 32'hFFFF_FFFC;
    lsu_wdata[k]     = 32'h5555_5555;
    lsu_wstrb[k]     = 4'hF;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 20 && pending(k) != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifu_req_valid[0] = 1'b1;
    lsu_req_valid[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if ({ram_wen[k], ram_wdata[k], ram_wstrb[k], ram_addr[k], ifu_resp_valid[k], lsu_resp_valid[k]} !== 71'd0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d wen=%b wdata=%h wstrb=%h addr=%h resp=%b%b, required all 0",
                 k, ram_wen[k], ram_wdata[k], ram_wstrb[k], ram_addr[k], ifu_resp_valid[k], lsu_resp_valid[k]);
      end
    end
    total++;
    if ({ifu_req_ready[0], lsu_req_ready[0]} !== 2'b10) begin
      bad++;
      $display("FAIL reset_tie_grant ifu/lsu ready=%b%b, required 10", ifu_req_ready[0], lsu_req_ready[0]);
    end
    ifu_req_valid[0] = 1'b0;
    lsu_req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ifu_read();
    bit ok;
    bit saw_wen = 1'b0;
    issue_ifu(0, 32'h8000_0000, 32'h0010_0093, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ifu_accept got=0 required=1"); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_wen[0]) saw_wen = 1'b1;
    end
    total++;
    if (saw_wen !== 1'b0) begin bad++; $display("FAIL ifu_read_wen got=1 required=0"); end
    drain(0);
    total++;
    if (pending(0) != 0) begin bad++; $display("FAIL ifu_read_timeout pending=%0d required=0", pending(0)); end
  endtask

  task automatic store_and_watch(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                 input logic [31:0] pre, output bit ok, output int nwen,
                                 output logic [67:0] seen);
    nwen = 0;
    seen = '0;
    issue_lsu(0, 1'b1, a, wd, ws, pre, 1'b1, ok);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ram_wen[0]) begin
        nwen++;
        seen = {ram_addr[0], ram_wdata[0], ram_wstrb[0]};
      end
    end
    drain(0);
  endtask

  task automatic test_store_load();
    bit          ok;
    int          nwen;
    logic [67:0] seen;
    logic [31:0] old;
    logic [31:0] exp_load;

    store_and_watch(32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, init_word(4), ok, nwen, seen);
    total++;
    if (!ok || nwen != 1) begin bad++; $display("FAIL store_wen_count accepted=%0d pulses=%0d required 1/1", ok, nwen); end
    total++;
    if (seen !== {32'h8000_0010, 32'hDEAD_BEEF, 4'b0011}) begin
      bad++;
      $display("FAIL store_ram_bus got=%h required=%h", seen, {32'h8000_0010, 32'hDEAD_BEEF, 4'b0011});
    end
    total++;
    if (pending(0) != 0) begin bad++; $display("FAIL store_resp_timeout pending=%0d required=0", pending(0)); end

    old      = init_word(4);
    exp_load = {old[31:16], 16'hBEEF};
    issue_lsu(0, 1'b0, 32'h8000_0010, 32'd0, 4'd0, exp_load, 1'b1, ok);
    drain(0);
    total++;
    if (!ok || pending(0) != 0) begin bad++; $display("FAIL merged_load accepted=%0d pending=%0d required 1/0", ok, pending(0)); end

    store_and_watch(32'h8000_0014, 32'hFFFF_FFFF, 4'b0000, init_word(5), ok, nwen, seen);
    total++;
    if (!ok || nwen != 1 || seen[3:0] !== 4'b0000) begin
      bad++;
      $display("FAIL zero_strobe_store accepted=%0d pulses=%0d wstrb=%h required 1/1/0", ok, nwen, seen[3:0]);
    end
    issue_lsu(0, 1'b0, 32'h8000_0014, 32'd0, 4'd0, init_word(5), 1'b1, ok);
    drain(0);
    total++;
    if (!ok || pending(0) != 0) begin bad++; $display("FAIL zero_strobe_load accepted=%0d pending=%0d required 1/0", ok, pending(0)); end
  endtask

  task automatic test_round_robin();
    int         ng = 0;
    logic [5:0] order = '0;
    logic [5:0] in_resp = '0;
    bit         both = 1'b0;
    @(posedge clk); #1;
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h8000_0020;
    lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'h8000_0024; lsu_wen[0] = 1'b0;
    for (int i = 0; i < 60 && ng < 6; i++) begin
      @(negedge clk);
      if (ifu_req_ready[0] && lsu_req_ready[0]) both = 1'b1;
      if (ifu_req_ready[0] || lsu_req_ready[0]) begin
        order[ng]   = lsu_req_ready[0];
        in_resp[ng] = ifu_resp_valid[0] | lsu_resp_valid[0];
        sb.push_back('{inst: 0, lsu: lsu_req_ready[0],
                       data: lsu_req_ready[0] ? init_word(9) : init_word(8), due: cyc + 2});
        ng++;
      end
      @(posedge clk);
    end
    #1;
    ifu_req_valid[0] = 1'b0;
    lsu_req_valid[0] = 1'b0;
    total++;
    if (ng != 6 || both) begin bad++; $display("FAIL rr_grants got=%0d both=%0d required 6/0", ng, both); end
    total++;
    if (order !== 6'b101010) begin bad++; $display("FAIL rr_order got=%b required=101010", order); end
    total++;
    if (in_resp !== 6'b111110) begin bad++; $display("FAIL rr_accept_in_resp got=%b required=111110", in_resp); end
    drain(0);
    total++;
    if (pending(0) != 0) begin bad++; $display("FAIL rr_timeout pending=%0d required=0", pending(0)); end
  endtask

  task automatic test_lsu_priority();
    int nl = 0;
    bit ifu_seen = 1'b0;
    bit gi = 1'b0;
    @(posedge clk); #1;
    ifu_req_valid[1] = 1'b1; ifu_addr[1] = 32'h8000_0028;
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 32'h8000_002C; lsu_wen[1] = 1'b0;
    for (int i = 0; i < 40 && nl < 4; i++) begin
      @(negedge clk);
      if (ifu_req_ready[1]) ifu_seen = 1'b1;
      if (lsu_req_ready[1]) begin
        sb.push_back('{inst: 1, lsu: 1'b1, data: init_word(11), due: cyc + 2});
        nl++;
      end
      @(posedge clk);
    end
    #1;
    lsu_req_valid[1] = 1'b0;
    for (int i = 0; i < 20 && !gi; i++) begin
      @(negedge clk);
      if (ifu_req_ready[1]) begin
        gi = 1'b1;
        sb.push_back('{inst: 1, lsu: 1'b0, data: init_word(10), due: cyc + 2});
      end
      @(posedge clk);
    end
    #1;
    ifu_req_valid[1] = 1'b0;
    total++;
    if (nl != 4 || ifu_seen) begin bad++; $display("FAIL prio_lsu_wins lsu_grants=%0d ifu_ready_seen=%0d required 4/0", nl, ifu_seen); end
    total++;
    if (!gi) begin bad++; $display("FAIL prio_ifu_after_drop got=0 required=1"); end
    drain(1);
    total++;
    if (pending(1) != 0) begin bad++; $display("FAIL prio_timeout pending=%0d required=0", pending(1)); end
  endtask

  task automatic test_latency4();
    bit ok;
    int stable = 0;
    int low = 0;
    bit saw_wen = 1'b0;
    issue_lsu(2, 1'b0, 32'h8000_000C, 32'd0, 4'd0, init_word(3), 1'b1, ok);
    ifu_req_valid[2] = 1'b1;
    ifu_addr[2]      = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_addr[2] === 32'h8000_000C) stable++;
      if (!ifu_req_ready[2] && !lsu_req_ready[2]) low++;
      if (ram_wen[2]) saw_wen = 1'b1;
    end
    @(posedge clk); #1;
    ifu_req_valid[2] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL lat4_accept got=0 required=1"); end
    total++;
    if (stable != 4 || saw_wen) begin bad++; $display("FAIL lat4_addr_stable cycles=%0d wen=%0d required 4/0", stable, saw_wen); end
    total++;
    if (low != 4) begin bad++; $display("FAIL lat4_ready_low cycles=%0d required=4", low); end
    drain(2);
    total++;
    if (pending(2) != 0) begin bad++; $display("FAIL lat4_timeout pending=%0d required=0", pending(2)); end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit saw_wen = 1'b0;
    bit saw_resp = 1'b0;
    issue_lsu(3, 1'b1, 32'h8000_0018, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, ok);
    @(negedge clk);
    if (ram_wen[3]) saw_wen = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_wen[3]) saw_wen = 1'b1;
      if (ifu_resp_valid[3] || lsu_resp_valid[3]) saw_resp = 1'b1;
    end
    total++;
    if (!ok || saw_wen || saw_resp) begin
      bad++;
      $display("FAIL reset_abort accepted=%0d wen=%0d resp=%0d required 1/0/0", ok, saw_wen, saw_resp);
    end
    @(posedge clk); #1;
    ifu_req_valid[3] = 1'b1; ifu_addr[3] = 32'h8000_0000;
    lsu_req_valid[3] = 1'b1; lsu_addr[3] = 32'h8000_0004; lsu_wen[3] = 1'b0;
    @(negedge clk);
    total++;
    if ({ifu_req_ready[3], lsu_req_ready[3]} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_tie ifu/lsu ready=%b%b required=10", ifu_req_ready[3], lsu_req_ready[3]);
    end
    if (ifu_req_ready[3]) sb.push_back('{inst: 3, lsu: 1'b0, data: init_word(0), due: cyc + 4});
    @(posedge clk); #1;
    ifu_req_valid[3] = 1'b0;
    lsu_req_valid[3] = 1'b0;
    drain(3);
    total++;
    if (pending(3) != 0) begin bad++; $display("FAIL post_reset_timeout pending=%0d required=0", pending(3)); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ifu_req_valid[k] = 1'b0; ifu_addr[k]  = 32'd0;
      lsu_req_valid[k] = 1'b0; lsu_wen[k]   = 1'b0;
      lsu_addr[k]      = 32'd0; lsu_wdata[k] = 32'd0; lsu_wstrb[k] = 4'd0;
    end
    test_reset();
    test_ifu_read();
    test_store_load();
    test_round_robin();
    test_lsu_priority();
    test_latency4();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover entries=%0d required=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
